uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Serial command front end for the Life core: receives 8N1 UART bytes from a host, assembles fixed 5-byte command frames, and presents each frame on the core's `cmd`/`cmd_arg0`/`cmd_valid`/`cmd_ready` command interface as its initiator. It sits on the board top between the UART pin driven by the USB-serial bridge and `top`. It is an alternative to the push-button command generator.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: `clk` cycles per UART bit (50 MHz / 115200). Must be ≥ 16.
- `TIMEOUT_BITS`, default 20: maximum idle gap, in bit periods, between bytes inside one frame.

Ports (clock and reset first):
- `clk`  in  1: single clock. All logic is in this domain.
- `reset`  in  1: synchronous, active-low. `reset == 0` at a rising edge resets the block.
- `uart_rx`  in  1: asynchronous serial line. Idle high.
- `cmd`  out  3: command opcode.
- `cmd_arg0`  out  32: command argument.
- `cmd_valid`  out  1: command pending.
- `cmd_ready`  in  1: core accepts the command.
- `frame_err`  out  1: one-cycle pulse on a bad stop bit, bad header, or timeout abort.
- `overrun`  out  1: one-cycle pulse when a completed frame is dropped.

## Operation
- **Input synchronizer:** `uart_rx` passes through a 2-FF synchronizer before any logic. The synchronizer resets to 1.
- **Byte receiver FSM:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronized falling edge enters START and clears the bit counter.
  - START: after `CLKS_PER_BIT/2` cycles, sample the line. If it is 1, treat it as a false start: return to IDLE with no error. If it is 0, enter DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles. 8 bits, LSB first, shifted into the byte register.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - Stop bit = 1: emit `byte_done` for one cycle.
    - Stop bit = 0: pulse `frame_err`, discard the byte, and return the frame assembler to HUNT.
    - In both cases return to IDLE immediately. No wait for the end of the stop bit.
- **Frame assembler FSM:** HUNT → ARG0 → ARG1 → ARG2 → ARG3.
  - HUNT: accept a byte as a header only when `byte[7:3] == 5'b10100`. `byte[2:0]` is the opcode. A non-matching byte pulses `frame_err` and stays in HUNT.
  - ARG0–ARG3: little-endian argument bytes. ARG0 → `arg[7:0]`, …, ARG3 → `arg[31:24]`.
  - After ARG3's `byte_done`, the frame is complete and the FSM returns to HUNT.
  - Timeout: in ARG0–ARG3, a bit-period counter counts idle time since the last `byte_done`. It reaches `TIMEOUT_BITS` only if no new start bit is in progress. On reaching it: pulse `frame_err`, return to HUNT, discard the partial frame.
- **Output register:**
  - On frame completion with `cmd_valid == 0`: load `cmd` and `cmd_arg0`, and set `cmd_valid`.
  - `cmd` and `cmd_arg0` are stable while `cmd_valid == 1`.
  - Handshake: `cmd_valid & cmd_ready` at a rising edge completes the transfer. `cmd_valid` falls on that edge unless reloaded.
  - A frame completing while `cmd_valid == 1` and `cmd_ready == 0`: the new frame is dropped, `overrun` pulses, and the held command is unchanged.
  - Completion coinciding with a handshake (`cmd_valid & cmd_ready` on the same edge): the new frame is loaded, `cmd_valid` stays 1, and there is no overrun.
- **Receiver independence:** the byte receiver keeps running while a command is pending. There is no backpressure on the serial line.

## Timing
- **Reset values:** `cmd` = 0, `cmd_arg0` = 0, `cmd_valid` = 0, `frame_err` = 0, `overrun` = 0. Both FSMs go to IDLE/HUNT, and all counters clear.
- **Reset mid-byte or mid-frame:** the partial byte or frame is discarded. A pending command is also discarded (`cmd_valid` = 0).
- **Sample points:** taken relative to the first cycle the synchronized line reads 0, at `CLKS_PER_BIT/2 + k*CLKS_PER_BIT` cycles for k = 0 (start), 1–8 (data), 9 (stop).
- **Latency:**
  - `cmd_valid` rises one cycle after the ARG3 stop-bit sample.
  - `frame_err` for a bad stop bit pulses one cycle after the stop sample.
  - Header-mismatch `frame_err` pulses one cycle after `byte_done`.
- **Minimum hold:** `cmd_valid` stays high for 1 cycle if `cmd_ready` is already high.

## Test plan
- **Nominal frame:** `CLKS_PER_BIT` = 16; send A3 78 56 34 12 → `cmd` = 3, `cmd_arg0` = 0x12345678, `cmd_valid` rises 1 cycle after the last stop sample. With `cmd_ready` = 1, `cmd_valid` lasts exactly 1 cycle. No errors.
- **Backpressure and overrun:**
  - Hold `cmd_ready` = 0 and send two frames, A1 01 00 00 00 then A2 02 00 00 00 → first command held (`cmd` = 1, arg 1), one `overrun` pulse.
  - Then `cmd_ready` = 1 → one handshake only.
  - Repeat with `cmd_ready` rising on the exact completion cycle of frame 2 → both commands delivered, no overrun.
- **Framing errors:**
  - Header 0x55 → `frame_err` pulse, no command.
  - Stop bit forced 0 on ARG1 → `frame_err`, assembler back in HUNT, no command.
  - A following valid frame A4 FF FF FF FF → `cmd` = 4, arg 0xFFFFFFFF.
- **Glitch and timeout:**
  - Low pulse of `CLKS_PER_BIT/4` cycles on idle line → no byte, no error.
  - Header A5 then silence for `TIMEOUT_BITS + 1` bit periods → one `frame_err`, no command.
- **Reset:**
  - Drive `reset` = 0 mid-ARG2 → all outputs 0.
  - After release, send the remaining bytes of the old frame → no command, one `frame_err` per non-header byte.
  - Then a full frame → delivered correctly.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// UART 8N1 command receiver: assembles 5-byte frames (header + 32-bit little-endian argument)
// and presents them on a valid/ready command interface with framing, timeout and overrun reporting.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [2:0]  cmd,
  output logic [31:0] cmd_arg0,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_BITS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {FA_HUNT, FA_ARG0, FA_ARG1, FA_ARG2, FA_ARG3} fa_state_t;

  logic          rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t     rx_state_r, rx_state_s;
  logic [CW-1:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    shift_r, shift_s;
  logic          byte_done_s, stop_err_s;
  fa_state_t     fa_state_r, fa_state_s;
  logic [2:0]    opcode_r, opcode_s;
  logic [31:0]   arg_r, arg_s;
  logic          hdr_err_s, frame_done_s, timeout_s;
  logic [CW-1:0] tick_cnt_r;
  logic [TW-1:0] idle_bits_r;

  // Line synchronizer, edge history and state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      baud_cnt_r <= {CW{1'b0}};
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      fa_state_r <= FA_HUNT;
      opcode_r   <= 3'd0;
      arg_r      <= 32'h0000_0000;
    end else begin
      rx_meta_r  <= uart_rx;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_state_r <= rx_state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      fa_state_r <= fa_state_s;
      opcode_r   <= opcode_s;
      arg_r      <= arg_s;
    end
  end

  // Byte receiver: mid-bit sampling timed from the synchronized falling edge
  always_comb begin
    rx_state_s  = rx_state_r;
    baud_cnt_s  = baud_cnt_r + CW'(1);
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    byte_done_s = 1'b0;
    stop_err_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        baud_cnt_s = {CW{1'b0}};
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_s = RX_START;
          bit_cnt_s  = 3'd0;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (baud_cnt_r == HALF_M1) begin
          baud_cnt_s = {CW{1'b0}};
          rx_state_s = rx_sync_r ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_s = RX_START;
        end
      end
      RX_DATA: begin
        if (baud_cnt_r == FULL_M1) begin
          baud_cnt_s = {CW{1'b0}};
          shift_s    = {rx_sync_r, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          rx_state_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (baud_cnt_r == FULL_M1) begin
          rx_state_s  = RX_IDLE;
          byte_done_s = rx_sync_r;
          stop_err_s  = !rx_sync_r;
        end else begin
          rx_state_s = RX_STOP;
        end
      end
      default: rx_state_s = RX_IDLE;
    endcase
  end

  // Inter-byte idle timer; frozen whenever a byte is on the wire or no frame is open
  always_ff @(posedge clk) begin
    if (!reset || byte_done_s || rx_state_r != RX_IDLE || fa_state_r == FA_HUNT) begin
      tick_cnt_r  <= {CW{1'b0}};
      idle_bits_r <= {TW{1'b0}};
    end else if (tick_cnt_r == FULL_M1) begin
      tick_cnt_r  <= {CW{1'b0}};
      idle_bits_r <= idle_bits_r + TW'(1);
    end else begin
      tick_cnt_r  <= tick_cnt_r + CW'(1);
    end
  end

  // Frame assembler: header match, little-endian argument collection, abort paths
  always_comb begin
    fa_state_s   = fa_state_r;
    opcode_s     = opcode_r;
    arg_s        = arg_r;
    hdr_err_s    = 1'b0;
    frame_done_s = 1'b0;
    timeout_s    = (fa_state_r != FA_HUNT) && (rx_state_r == RX_IDLE) &&
                   (tick_cnt_r == FULL_M1) && (idle_bits_r == TO_M1);
    if (stop_err_s || timeout_s) begin
      fa_state_s = FA_HUNT;
    end else if (byte_done_s) begin
      case (fa_state_r)
        FA_HUNT: begin
          if (shift_r[7:3] == 5'b10100) begin
            opcode_s   = shift_r[2:0];
            fa_state_s = FA_ARG0;
          end else begin
            hdr_err_s  = 1'b1;
          end
        end
        FA_ARG0: begin arg_s[7:0]   = shift_r; fa_state_s = FA_ARG1; end
        FA_ARG1: begin arg_s[15:8]  = shift_r; fa_state_s = FA_ARG2; end
        FA_ARG2: begin arg_s[23:16] = shift_r; fa_state_s = FA_ARG3; end
        FA_ARG3: begin
          arg_s[31:24] = shift_r;
          frame_done_s = 1'b1;
          fa_state_s   = FA_HUNT;
        end
        default: fa_state_s = FA_HUNT;
      endcase
    end else begin
      fa_state_s = fa_state_r;
    end
  end

  // Command holding register with handshake, overrun and error pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd       <= 3'd0;
      cmd_arg0  <= 32'h0000_0000;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_err_s | hdr_err_s | timeout_s;
      overrun   <= 1'b0;
      if (frame_done_s) begin
        if (!cmd_valid || cmd_ready) begin
          cmd       <= opcode_r;
          cmd_arg0  <= arg_s;
          cmd_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end else begin
        cmd_valid <= cmd_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: frame-level reference model compared every cycle, plus directed
// literal expectations for each scenario.
module tb_uart_cmd_rx;
  localparam int CPB = 16;
  localparam int TOB = 20;
  localparam int H   = CPB / 2;
  // cycles from driving the start bit to the stop-bit sample (2 sync stages + 9.5 bits)
  localparam int LAT = 2 + H + 9 * CPB;

  logic clk = 1'b0, reset = 1'b0, uart_rx = 1'b1, cmd_ready = 1'b0;
  logic [2:0] cmd;
  logic [31:0] cmd_arg0;
  logic cmd_valid, frame_err, overrun;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .cmd(cmd), .cmd_arg0(cmd_arg0),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .frame_err(frame_err), .overrun(overrun));

  initial forever #5 clk = ~clk;

  typedef struct packed { int stop_cyc; logic [7:0] data; logic ok; } ev_t;
  ev_t evq[$];
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  bit model_on = 1'b0;
  logic [2:0] exp_cmd = 3'd0;
  logic [31:0] exp_arg = 32'd0;
  logic exp_valid = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;
  int ferr_cnt = 0, ovr_cnt = 0, valid_cnt = 0, valid_rise = -1;
  logic prev_valid = 1'b0;
  logic [2:0] dl_cmd[$];
  logic [31:0] dl_arg[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: byte events in, frame rules applied at frame level
  initial begin : model
    int cur, nb, last_done;
    ev_t ev;
    bit done;
    logic [2:0] opc;
    logic [31:0] arg;
    nb = 0; last_done = 0; opc = 3'd0; arg = 32'd0;
    forever begin
      @(posedge clk);
      cur = cyc;
      exp_ferr = 1'b0;
      exp_ovr = 1'b0;
      done = 1'b0;
      if (!reset) begin
        model_on = 1'b1;
        exp_cmd = 3'd0; exp_arg = 32'd0; exp_valid = 1'b0;
        nb = 0; evq.delete();
      end else begin
        if (evq.size() > 0 && evq[0].stop_cyc == cur) begin
          ev = evq.pop_front();
          if (!ev.ok) begin
            exp_ferr = 1'b1; nb = 0;
          end else if (nb == 0) begin
            if (ev.data[7:3] == 5'b10100) begin
              opc = ev.data[2:0]; nb = 1; last_done = cur;
            end else exp_ferr = 1'b1;
          end else begin
            arg[8*(nb-1) +: 8] = ev.data;
            last_done = cur;
            if (nb == 4) begin done = 1'b1; nb = 0; end
            else nb++;
          end
        end else if (nb != 0 && evq.size() == 0 && cur - last_done == TOB * CPB) begin
          exp_ferr = 1'b1; nb = 0;
        end
        if (done) begin
          if (!exp_valid || cmd_ready) begin
            exp_cmd = opc; exp_arg = arg; exp_valid = 1'b1;
          end else exp_ovr = 1'b1;
        end else if (exp_valid && cmd_ready) exp_valid = 1'b0;
      end
      cyc = cyc + 1;
    end
  end

  // Per-cycle comparison and event monitor
  initial begin : compare
    forever begin
      @(negedge clk);
      if (model_on) begin
        chk("cmd", cmd, exp_cmd);
        chk("cmd_arg0", cmd_arg0, exp_arg);
        chk("cmd_valid", cmd_valid, exp_valid);
        chk("frame_err", frame_err, exp_ferr);
        chk("overrun", overrun, exp_ovr);
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (cmd_valid) valid_cnt++;
        if (cmd_valid && !prev_valid) valid_rise = cyc;
        prev_valid = cmd_valid;
        if (cmd_valid && cmd_ready) begin
          dl_cmd.push_back(cmd);
          dl_arg.push_back(cmd_arg0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit ready_at_done);
    ev_t ev;
    ev.stop_cyc = cyc + LAT; ev.data = b; ev.ok = stop_ok;
    evq.push_back(ev);
    uart_rx = 1'b0; repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (CPB) tick(); end
    uart_rx = stop_ok;
    repeat (H + 2) tick();
    if (ready_at_done) cmd_ready = 1'b1;
    repeat (CPB - H - 2) tick();
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] a, input bit ready_at_done);
    send_byte(hdr, 1'b1, 1'b0);
    send_byte(a[7:0], 1'b1, 1'b0);
    send_byte(a[15:8], 1'b1, 1'b0);
    send_byte(a[23:16], 1'b1, 1'b0);
    send_byte(a[31:24], 1'b1, ready_at_done);
  endtask

  initial begin : driver
    int d0, f0, o0, v0, n0;
    idle(4);
    reset = 1'b1;
    tick();
    chk("rst_cmd", cmd, 32'd0);
    chk("rst_arg", cmd_arg0, 32'd0);
    chk("rst_valid", cmd_valid, 32'd0);
    chk("rst_ferr", frame_err, 32'd0);
    chk("rst_ovr", overrun, 32'd0);

    // nominal frame, core always ready
    cmd_ready = 1'b1;
    d0 = dl_cmd.size(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cnt;
    send_byte(8'hA3, 1'b1, 1'b0); send_byte(8'h78, 1'b1, 1'b0);
    send_byte(8'h56, 1'b1, 1'b0); send_byte(8'h34, 1'b1, 1'b0);
    n0 = cyc;
    send_byte(8'h12, 1'b1, 1'b0);
    idle(20);
    chk("nom_deliv", dl_cmd.size() - d0, 32'd1);
    chk("nom_cmd", dl_cmd[dl_cmd.size()-1], 32'd3);
    chk("nom_arg", dl_arg[dl_arg.size()-1], 32'h12345678);
    chk("nom_latency", valid_rise - n0, 32'd155);
    chk("nom_width", valid_cnt - v0, 32'd1);
    chk("nom_ferr", ferr_cnt - f0, 32'd0);
    chk("nom_ovr", ovr_cnt - o0, 32'd0);
    chk("model_cmd", exp_cmd, 32'd3);
    chk("model_arg", exp_arg, 32'h12345678);

    // backpressure: second frame dropped
    cmd_ready = 1'b0;
    d0 = dl_cmd.size(); o0 = ovr_cnt;
    send_frame(8'hA1, 32'h00000001, 1'b0);
    send_frame(8'hA2, 32'h00000002, 1'b0);
    idle(20);
    chk("ovr_held_cmd", cmd, 32'd1);
    chk("ovr_held_arg", cmd_arg0, 32'd1);
    chk("ovr_held_valid", cmd_valid, 32'd1);
    chk("ovr_pulses", ovr_cnt - o0, 32'd1);
    cmd_ready = 1'b1;
    idle(10);
    chk("ovr_deliv", dl_cmd.size() - d0, 32'd1);
    chk("ovr_deliv_cmd", dl_cmd[dl_cmd.size()-1], 32'd1);

    // ready rises on the completion cycle of frame 2: both delivered
    cmd_ready = 1'b0;
    d0 = dl_cmd.size(); o0 = ovr_cnt;
    send_frame(8'hA1, 32'h00000001, 1'b0);
    send_frame(8'hA2, 32'h00000002, 1'b1);
    idle(20);
    chk("coin_deliv", dl_cmd.size() - d0, 32'd2);
    chk("coin_cmd1", dl_cmd[dl_cmd.size()-2], 32'd1);
    chk("coin_cmd2", dl_cmd[dl_cmd.size()-1], 32'd2);
    chk("coin_arg2", dl_arg[dl_arg.size()-1], 32'd2);
    chk("coin_ovr", ovr_cnt - o0, 32'd0);

    // bad header
    d0 = dl_cmd.size(); f0 = ferr_cnt;
    send_byte(8'h55, 1'b1, 1'b0);
    idle(10);
    chk("hdr_ferr", ferr_cnt - f0, 32'd1);
    chk("hdr_deliv", dl_cmd.size() - d0, 32'd0);

    // bad stop bit on ARG1, then a clean frame
    f0 = ferr_cnt;
    send_byte(8'hA1, 1'b1, 1'b0); send_byte(8'h10, 1'b1, 1'b0); send_byte(8'h20, 1'b0, 1'b0);
    idle(10);
    chk("stop_ferr", ferr_cnt - f0, 32'd1);
    chk("stop_deliv", dl_cmd.size() - d0, 32'd0);
    f0 = ferr_cnt;
    send_frame(8'hA4, 32'hFFFFFFFF, 1'b0);
    idle(20);
    chk("after_stop_deliv", dl_cmd.size() - d0, 32'd1);
    chk("after_stop_cmd", dl_cmd[dl_cmd.size()-1], 32'd4);
    chk("after_stop_arg", dl_arg[dl_arg.size()-1], 32'hFFFFFFFF);
    chk("after_stop_ferr", ferr_cnt - f0, 32'd0);

    // glitch on idle line
    d0 = dl_cmd.size(); f0 = ferr_cnt;
    uart_rx = 1'b0; idle(CPB / 4); uart_rx = 1'b1;
    idle(3 * CPB);
    chk("glitch_ferr", ferr_cnt - f0, 32'd0);
    chk("glitch_deliv", dl_cmd.size() - d0, 32'd0);

    // header then silence
    send_byte(8'hA5, 1'b1, 1'b0);
    idle((TOB + 1) * CPB);
    chk("tmo_ferr", ferr_cnt - f0, 32'd1);
    chk("tmo_deliv", dl_cmd.size() - d0, 32'd0);

    // reset with a pending command and a frame parked in ARG2
    cmd_ready = 1'b0;
    send_frame(8'hA7, 32'hCAFEF00D, 1'b0);
    send_byte(8'hA6, 1'b1, 1'b0); send_byte(8'h11, 1'b1, 1'b0); send_byte(8'h22, 1'b1, 1'b0);
    idle(4);
    chk("pre_rst_valid", cmd_valid, 32'd1);
    reset = 1'b0;
    idle(2);
    chk("mid_rst_cmd", cmd, 32'd0);
    chk("mid_rst_arg", cmd_arg0, 32'd0);
    chk("mid_rst_valid", cmd_valid, 32'd0);
    reset = 1'b1;
    cmd_ready = 1'b1;
    tick();
    d0 = dl_cmd.size(); f0 = ferr_cnt;
    send_byte(8'h33, 1'b1, 1'b0); send_byte(8'h44, 1'b1, 1'b0);
    idle(10);
    chk("post_rst_ferr", ferr_cnt - f0, 32'd2);
    chk("post_rst_deliv", dl_cmd.size() - d0, 32'd0);
    send_frame(8'hA2, 32'h89ABCDEF, 1'b0);
    idle(20);
    chk("post_rst_frame", dl_cmd.size() - d0, 32'd1);
    chk("post_rst_cmd", dl_cmd[dl_cmd.size()-1], 32'd2);
    chk("post_rst_arg", dl_arg[dl_arg.size()-1], 32'h89ABCDEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
